// File: rtl/apb_spi_ctrl.sv
// APB3 front end for the CPOL=1/CPHA=1 SPI byte engine: TX/RX byte FIFOs, read-request counter, start sequencer.
// Start pulse two cycles after a TXDATA write; no APB wait states, full/empty FIFO accesses answer with pslverr.

module apb_spi_fifo #(
   parameter int DEPTH = 8,
   parameter int W = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          arstn,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [W-1:0]  pop_dat,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // full/empty come from the pre-edge count, so a push to a full FIFO is refused even alongside a pop
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push & ~do_pop)      count <= count + CW'(1);
         else if (do_pop & ~do_push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module apb_spi_ctrl #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        arstn,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [4:0]  paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic [7:0]  spi_byte_send,
   output logic        spi_send_byte,
   output logic        spi_receive_byte,
   input  logic [7:0]  spi_byte_receive,
   input  logic        spi_system_idle,
   input  logic        spi_new_byte,
   output logic        irq
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} state_t;
   state_t state, state_nxt;

   logic          ctrl_en, rx_en, irq_en, rx_ovf, start_tx;
   logic [7:0]    rd_req, rd_req_nxt, rd_add;
   logic [8:0]    rd_sum;
   logic          access, ctrl_wr, rd_dec, rx_drop;
   logic          tx_push, tx_pop, tx_full, tx_empty;
   logic          rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]    tx_head, rx_head;
   logic [CW-1:0] tx_count, rx_count;
   logic [31:0]   status;
   logic          unused_ok;

   assign unused_ok = &{1'b0, paddr[1:0], pwdata[31:8]};
   assign pready    = 1'b1;
   assign access    = psel & penable;
   assign status    = {rd_req, 8'(rx_count), 8'(tx_count), 2'b00, rx_ovf, (state != S_IDLE),
                       rx_full, rx_empty, tx_full, tx_empty};

   apb_spi_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
      .clk(clk), .arstn(arstn), .push(tx_push), .push_dat(pwdata[7:0]), .pop(tx_pop),
      .pop_dat(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty));

   apb_spi_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
      .clk(clk), .arstn(arstn), .push(rx_push), .push_dat(spi_byte_receive), .pop(rx_pop),
      .pop_dat(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty));

   always_comb begin
      prdata  = '0;
      pslverr = 1'b0;
      tx_push = 1'b0;
      rx_pop  = 1'b0;
      ctrl_wr = 1'b0;
      rd_add  = '0;
      if (access) begin
         case (paddr[4:2])
            3'd0: if (pwrite) begin
               tx_push = ~tx_full;
               pslverr = tx_full;
            end
            3'd1: if (!pwrite) begin
               if (rx_empty) pslverr = 1'b1;
               else begin
                  prdata = {24'b0, rx_head};
                  rx_pop = 1'b1;
               end
            end
            3'd2: if (!pwrite) prdata = status;
            3'd3: begin
               if (pwrite) ctrl_wr = 1'b1;
               else        prdata  = {29'b0, irq_en, rx_en, ctrl_en};
            end
            3'd4: begin
               if (pwrite) rd_add = pwdata[7:0];
               else        prdata = {24'b0, rd_req};
            end
            default: pslverr = 1'b1;
         endcase
      end
   end

   // rd_dec only fires with rd_req non-zero, so the sum never underflows
   assign rd_sum     = {1'b0, rd_req} + {1'b0, rd_add} - {8'b0, rd_dec};
   assign rd_req_nxt = rd_sum[8] ? 8'hFF : rd_sum[7:0];

   always_comb begin
      state_nxt        = state;
      tx_pop           = 1'b0;
      rd_dec           = 1'b0;
      spi_send_byte    = 1'b0;
      spi_receive_byte = 1'b0;
      rx_push          = 1'b0;
      rx_drop          = 1'b0;
      case (state)
         S_IDLE: if (ctrl_en && spi_system_idle && (!tx_empty || rd_req != 8'd0)) begin
            state_nxt = S_START;
            if (!tx_empty) tx_pop = 1'b1;
            else           rd_dec = 1'b1;
         end
         S_START: begin
            spi_send_byte    = start_tx;
            spi_receive_byte = ~start_tx;
            state_nxt        = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: if (!spi_system_idle) state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: if (spi_new_byte) begin
            state_nxt = S_IDLE;
            rx_push   = rx_en;
            rx_drop   = rx_en & rx_full;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state         <= S_IDLE;
         ctrl_en       <= 1'b0;
         rx_en         <= 1'b0;
         irq_en        <= 1'b0;
         rx_ovf        <= 1'b0;
         start_tx      <= 1'b0;
         rd_req        <= '0;
         spi_byte_send <= '0;
         irq           <= 1'b0;
      end else begin
         state  <= state_nxt;
         rd_req <= rd_req_nxt;
         if (tx_pop) begin
            spi_byte_send <= tx_head;
            start_tx      <= 1'b1;
         end else if (rd_dec) begin
            start_tx <= 1'b0;
         end
         if (ctrl_wr) begin
            ctrl_en <= pwdata[0];
            rx_en   <= pwdata[1];
            irq_en  <= pwdata[2];
            if (pwdata[3]) rx_ovf <= 1'b0;
         end
         if (rx_drop) rx_ovf <= 1'b1;
         irq <= irq_en & (~rx_empty | rx_ovf);
      end
   end
endmodule

// File: tb/tb_apb_spi_ctrl.sv
// Directed plus randomized bench for apb_spi_ctrl with a behavioural SPI engine responder.
module tb_apb_spi_ctrl;
   localparam int DEPTH = 8;
   localparam logic [4:0] A_TXD = 5'h00, A_RXD = 5'h04, A_STAT = 5'h08, A_CTRL = 5'h0C, A_RDREQ = 5'h10;

   logic        clk, arstn, psel, penable, pwrite;
   logic [4:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr;
   logic [7:0]  spi_byte_send, spi_byte_receive;
   logic        spi_send_byte, spi_receive_byte, spi_system_idle, spi_new_byte, irq;

   int n_assert = 0;
   int n_fail   = 0;

   // engine responder state: log entries are {is_tx, byte at start, byte at completion}
   int          eng_len = 3;
   int          eng_starts = 0;
   bit          eng_act = 0;
   logic [7:0]  dummy_q [$];
   logic [16:0] eng_log [$];

   apb_spi_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .arstn(arstn), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .spi_byte_send(spi_byte_send), .spi_send_byte(spi_send_byte),
      .spi_receive_byte(spi_receive_byte), .spi_byte_receive(spi_byte_receive),
      .spi_system_idle(spi_system_idle), .spi_new_byte(spi_new_byte), .irq(irq));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // SPI engine: loopback for TX transfers, bench-supplied bytes for dummy transfers
   initial begin
      logic [16:0] ev;
      spi_system_idle  = 1'b1;
      spi_new_byte     = 1'b0;
      spi_byte_receive = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (spi_send_byte || spi_receive_byte) begin
            eng_starts++;
            eng_act = 1'b1;
            ev[16] = spi_send_byte;
            ev[15:8] = spi_byte_send;
            spi_system_idle = 1'b0;
            repeat (eng_len) @(posedge clk);
            #1;
            ev[7:0] = spi_byte_send;
            if (ev[16]) spi_byte_receive = ev[15:8];
            else if (dummy_q.size() > 0) spi_byte_receive = dummy_q.pop_front();
            else spi_byte_receive = 8'hEE;
            spi_new_byte    = 1'b1;
            spi_system_idle = 1'b1;
            @(posedge clk); #1;
            spi_new_byte = 1'b0;
            eng_act      = 1'b0;
            eng_log.push_back(ev);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apb_xfer(input logic w, input logic [4:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic err);
      psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      rd  = prdata;
      err = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_wr(input logic [4:0] a, input logic [31:0] d, output logic err);
      logic [31:0] unused_rd;
      apb_xfer(1'b1, a, d, unused_rd, err);
   endtask

   task automatic apb_rd(input logic [4:0] a, output logic [31:0] d, output logic err);
      apb_xfer(1'b0, a, 32'h0, d, err);
   endtask

   function automatic logic [31:0] status_word(input int txc, input int rxc, input bit busy,
                                               input bit ovf, input int rdq);
      return 32'(rdq << 24) | 32'(rxc << 16) | 32'(txc << 8) | (ovf ? 32'h20 : 32'h0) |
             (busy ? 32'h10 : 32'h0) | (rxc == DEPTH ? 32'h8 : 32'h0) | (rxc == 0 ? 32'h4 : 32'h0) |
             (txc == DEPTH ? 32'h2 : 32'h0) | (txc == 0 ? 32'h1 : 32'h0);
   endfunction

   task automatic wait_done(input string tag);
      logic [31:0] st;
      logic        e;
      bit          ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         apb_rd(A_STAT, st, e);
         if (!eng_act && !st[4] && st[0] && st[31:24] == 8'd0) ok = 1'b1;
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic wait_start(input int base, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(posedge clk); #2;
         if (eng_starts > base) ok = 1'b1;
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   initial begin
      logic [31:0] rd, st;
      logic        e;
      logic [7:0]  b, x;
      logic [7:0]  exp_rx [$];
      logic [7:0]  sent [$];
      int          base, k, n, tot, keep;
      bit          ok;

      arstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      #3;
      check("rst_prdata", prdata, 32'h0);
      check("rst_pready", 32'(pready), 32'd1);
      check("rst_outs", 32'({pslverr, spi_send_byte, spi_receive_byte, irq, spi_byte_send}), 32'h0);
      repeat (2) @(posedge clk);
      #1 arstn = 1'b1;
      @(posedge clk); #1;
      apb_rd(A_STAT, rd, e);
      check("rst_status", rd, 32'h5);
      apb_rd(A_CTRL, rd, e);
      check("rst_ctrl", rd, 32'h0);

      // basic TX with exact start latency
      apb_wr(A_CTRL, 32'h1, e);
      apb_wr(A_TXD, 32'hA5, e);
      check("basic_push_err", 32'(e), 32'd0);
      check("basic_no_early_start", 32'({spi_send_byte, spi_receive_byte}), 32'd0);
      @(posedge clk); #1;
      check("basic_start_pulse", 32'({spi_send_byte, spi_receive_byte}), 32'b10);
      check("basic_byte_send", 32'(spi_byte_send), 32'hA5);
      wait_done("basic_done");
      check("basic_nstarts", 32'(eng_log.size()), 32'd1);
      check("basic_log", 32'(eng_log[0]), 32'h1A5A5);
      apb_rd(A_STAT, rd, e);
      check("basic_status", rd, status_word(0, 0, 0, 0, 0));

      // loopback RX
      apb_wr(A_CTRL, 32'h3, e);
      apb_wr(A_TXD, 32'h3C, e);
      wait_done("loop_done");
      apb_rd(A_RXD, rd, e);
      check("loop_rx_data", rd, 32'h3C);
      check("loop_rx_err", 32'(e), 32'd0);
      apb_rd(A_RXD, rd, e);
      check("loop_empty_data", rd, 32'h0);
      check("loop_empty_err", 32'(e), 32'd1);

      // TX full, then RX overflow with nine transfers
      apb_wr(A_CTRL, 32'h0, e);
      eng_log.delete(); exp_rx.delete(); dummy_q.delete();
      for (int i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom);
         apb_wr(A_TXD, {24'b0, b}, e);
         if (i < DEPTH) exp_rx.push_back(b);
         check("full_push_err", 32'(e), (i == DEPTH) ? 32'd1 : 32'd0);
      end
      apb_rd(A_STAT, rd, e);
      check("full_status", rd, status_word(DEPTH, 0, 0, 0, 0));
      dummy_q.push_back(8'h77);
      apb_wr(A_RDREQ, 32'h1, e);
      apb_wr(A_CTRL, 32'h3, e);
      wait_done("ovf_done");
      check("ovf_nstarts", 32'(eng_log.size()), 32'(DEPTH + 1));
      apb_rd(A_STAT, rd, e);
      check("ovf_status", rd, status_word(0, DEPTH, 0, 1, 0));
      apb_wr(A_CTRL, 32'hB, e);
      apb_rd(A_STAT, rd, e);
      check("ovf_cleared", rd, status_word(0, DEPTH, 0, 0, 0));
      apb_rd(A_CTRL, rd, e);
      check("ctrl_readback", rd, 32'h3);
      for (int i = 0; i < DEPTH; i++) begin
         apb_rd(A_RXD, rd, e);
         check("ovf_rx_data", rd, 32'(exp_rx[i]));
      end

      // read requests yield to queued TX
      apb_wr(A_CTRL, 32'h2, e);
      eng_log.delete(); dummy_q.delete(); exp_rx.delete();
      x = 8'($urandom);
      exp_rx.push_back(x);
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         dummy_q.push_back(b);
         exp_rx.push_back(b);
      end
      apb_wr(A_TXD, {24'b0, x}, e);
      apb_wr(A_RDREQ, 32'h3, e);
      apb_rd(A_RDREQ, rd, e);
      check("prio_rdreq_before", rd, 32'd3);
      apb_wr(A_CTRL, 32'h3, e);
      wait_done("prio_done");
      check("prio_nstarts", 32'(eng_log.size()), 32'd4);
      check("prio_first_tx", 32'(eng_log[0][16:8]), 32'(9'h100 | x));
      for (int i = 1; i < 4; i++) check("prio_dummy", 32'(eng_log[i][16]), 32'd0);
      apb_rd(A_RDREQ, rd, e);
      check("prio_rdreq_after", rd, 32'd0);
      for (int i = 0; i < 4; i++) begin
         apb_rd(A_RXD, rd, e);
         check("prio_rx_data", rd, 32'(exp_rx[i]));
      end

      // randomized rounds against the queue model
      for (int r = 0; r < 4; r++) begin
         k = $urandom_range(1, DEPTH);
         n = $urandom_range(0, 4);
         tot = k + n;
         keep = (tot > DEPTH) ? DEPTH : tot;
         eng_len = $urandom_range(2, 6);
         eng_log.delete(); dummy_q.delete(); exp_rx.delete(); sent.delete();
         apb_wr(A_CTRL, 32'h2, e);
         for (int i = 0; i < k; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            apb_wr(A_TXD, {24'b0, b}, e);
         end
         for (int i = 0; i < n; i++) dummy_q.push_back(8'($urandom));
         for (int i = 0; i < k; i++) exp_rx.push_back(sent[i]);
         foreach (dummy_q[i]) exp_rx.push_back(dummy_q[i]);
         apb_wr(A_RDREQ, 32'(n), e);
         apb_wr(A_CTRL, 32'h3, e);
         wait_done("rnd_done");
         check("rnd_nstarts", 32'(eng_log.size()), 32'(tot));
         for (int i = 0; i < eng_log.size(); i++) begin
            check("rnd_kind", 32'(eng_log[i][16]), (i < k) ? 32'd1 : 32'd0);
            check("rnd_byte_stable", 32'(eng_log[i][15:8]), 32'(eng_log[i][7:0]));
            if (i < k) check("rnd_tx_byte", 32'(eng_log[i][15:8]), 32'(sent[i]));
         end
         apb_rd(A_STAT, rd, e);
         check("rnd_status", rd, status_word(0, keep, 0, tot > DEPTH, 0));
         for (int i = 0; i < keep; i++) begin
            apb_rd(A_RXD, rd, e);
            check("rnd_rx_data", rd, 32'(exp_rx[i]));
         end
         apb_wr(A_CTRL, 32'hA, e);
      end
      eng_len = 3;

      // clearing enable mid-transfer
      exp_rx.delete();
      apb_wr(A_CTRL, 32'h2, e);
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         exp_rx.push_back(b);
         apb_wr(A_TXD, {24'b0, b}, e);
      end
      eng_len = 10;
      base = eng_starts;
      apb_wr(A_CTRL, 32'h3, e);
      wait_start(base, "dis_start_seen");
      @(posedge clk); #1;
      @(posedge clk); #1;
      apb_wr(A_CTRL, 32'h2, e);
      repeat (20) @(posedge clk);
      #1;
      check("dis_one_start", 32'(eng_starts - base), 32'd1);
      apb_rd(A_STAT, rd, e);
      check("dis_status", rd, status_word(2, 1, 0, 0, 0));
      eng_len = 3;
      apb_wr(A_CTRL, 32'h3, e);
      wait_done("dis_resume_done");
      for (int i = 0; i < 3; i++) begin
         apb_rd(A_RXD, rd, e);
         check("dis_rx_data", rd, 32'(exp_rx[i]));
      end

      // interrupt from RX data
      apb_wr(A_CTRL, 32'h7, e);
      x = 8'($urandom);
      apb_wr(A_TXD, {24'b0, x}, e);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(posedge clk); #2;
         if (spi_new_byte) ok = 1'b1;
      end
      check("irq_new_byte_seen", 32'(ok), 32'd1);
      check("irq_low_before_push", 32'(irq), 32'd0);
      ok = 1'b0;
      for (int i = 0; i < 3 && !ok; i++) begin
         @(posedge clk); #2;
         if (irq) ok = 1'b1;
      end
      check("irq_rises", 32'(ok), 32'd1);
      apb_rd(A_RXD, rd, e);
      check("irq_rx_data", rd, 32'(x));
      ok = 1'b0;
      for (int i = 0; i < 3 && !ok; i++) begin
         @(posedge clk); #2;
         if (!irq) ok = 1'b1;
      end
      check("irq_falls", 32'(ok), 32'd1);
      @(posedge clk); #1;

      // address decode corners and RDREQ saturation
      apb_wr(A_CTRL, 32'h0, e);
      apb_rd(5'h14, rd, e);
      check("bad_rd_data", rd, 32'h0);
      check("bad_rd_err", 32'(e), 32'd1);
      apb_wr(5'h18, 32'hFF, e);
      check("bad_wr_err", 32'(e), 32'd1);
      apb_rd(A_TXD, rd, e);
      check("txd_read", 32'({e, rd[30:0]}), 32'h0);
      apb_wr(A_RDREQ, 32'd250, e);
      apb_wr(A_RDREQ, 32'd10, e);
      apb_rd(A_RDREQ, rd, e);
      check("rdreq_saturate", rd, 32'd255);

      // reset in the middle of a TX transfer
      apb_wr(A_TXD, 32'h5A, e);
      eng_len = 8;
      base = eng_starts;
      apb_wr(A_CTRL, 32'h1, e);
      wait_start(base, "rst_start_seen");
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_mid_byte_hold", 32'(spi_byte_send), 32'h5A);
      #2 arstn = 1'b0;
      #1;
      check("rstmid_prdata", prdata, 32'h0);
      check("rstmid_pready", 32'(pready), 32'd1);
      check("rstmid_outs", 32'({pslverr, spi_send_byte, spi_receive_byte, irq, spi_byte_send}), 32'h0);
      @(posedge clk); #1;
      arstn = 1'b1;
      @(posedge clk); #1;
      apb_rd(A_STAT, st, e);
      check("rstmid_status", st, 32'h5);
      apb_rd(A_RDREQ, rd, e);
      check("rstmid_rdreq", rd, 32'h0);
      apb_rd(A_CTRL, rd, e);
      check("rstmid_ctrl", rd, 32'h0);
      base = eng_starts;
      repeat (20) @(posedge clk);
      #1;
      check("rstmid_no_restart", 32'(eng_starts - base), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
